ecp5pll_phase_ctrl: RTL and testbench

- Initiator for the ECP5 PLL dynamic phase-shift port (phasesel/phasedir/phasestep/phaseloadreg/locked).
- Accepts commands of the form "shift output N by K fine steps" over a valid/ready handshake.
- Sequences phasesel/phasedir setup, phasestep pulses and inter-step gaps, then optionally waits for PLL lock.
- Keeps a running signed phase-step total per secondary output for software readback. Sits between a control bus (SPI/register file) and the PLL wrapper instance.

---
 rtl/ecp5pll_phase_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ecp5pll_phase_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ecp5pll_phase_ctrl.sv
// Command-driven sequencer for the ECP5 PLL dynamic phase-shift port. It holds
// phasesel/phasedir, issues phasestep pulses with gaps, and keeps per-output step totals.
module ecp5pll_phase_ctrl #(
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned PULSE_CYC   = 4,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned LOCK_WAIT   = 1,
  parameter int unsigned TIMEOUT_CYC = 65535,
  parameter int unsigned STEP_W      = 10
) (
  input  logic                     clk_i,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_sel,
  input  logic signed [STEP_W-1:0] cmd_steps,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic signed [15:0]       acc1,
  output logic signed [15:0]       acc2,
  output logic signed [15:0]       acc3,
  input  logic                     locked,
  output logic [1:0]               phasesel,
  output logic                     phasedir,
  output logic                     phasestep,
  output logic                     phaseloadreg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_GAP   = 3'd3,
    S_LOCKW = 3'd4,
    S_FIN   = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  localparam logic [7:0]        SETUP_LAST = 8'(SETUP_CYC - 1);
  localparam logic [7:0]        PULSE_LAST = 8'(PULSE_CYC - 1);
  localparam logic [7:0]        GAP_LAST   = 8'(GAP_CYC - 1);
  localparam logic [19:0]       LOCK_LAST  = 20'(TIMEOUT_CYC - 1);
  localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};

  // Unsigned magnitude; the most negative input maps to 2^(STEP_W-1).
  function automatic logic [STEP_W-1:0] step_mag(input logic [STEP_W-1:0] s);
    return s[STEP_W-1] ? (~s + STEP_ONE) : s;
  endfunction

  function automatic logic [15:0] acc_bump(input logic [15:0] a, input logic dir);
    return dir ? (a - 16'd1) : (a + 16'd1);
  endfunction

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [19:0]       lock_cnt_q, lock_cnt_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [1:0]        phasesel_q, phasesel_d;
  logic              phasedir_q, phasedir_d;
  logic [15:0]       acc1_q, acc1_d, acc2_q, acc2_d, acc3_q, acc3_d;
  logic [1:0]        lock_sync_q;
  logic              cmd_ready_q, busy_q, done_q, err_q, phasestep_q;
  logic              accept_s;

  assign accept_s = cmd_valid & cmd_ready_q;

  // Next-state and datapath updates for the phase-step sequencer.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 8'd1;
    lock_cnt_d = 20'd0;
    rem_d      = rem_q;
    phasesel_d = phasesel_q;
    phasedir_d = phasedir_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    acc3_d     = acc3_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = 8'd0;
        if (accept_s) begin
          if (cmd_sel == 2'd0) begin
            state_d = S_ERR;
          end else if (cmd_steps == '0) begin
            state_d = S_FIN;
          end else begin
            state_d    = S_SETUP;
            phasesel_d = cmd_sel;
            phasedir_d = cmd_steps[STEP_W-1];
            rem_d      = step_mag(cmd_steps);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = S_PULSE;
          cnt_d   = 8'd0;
        end else begin
          state_d = S_SETUP;
        end
      end
      S_PULSE: begin
        if (cnt_q == PULSE_LAST) begin
          // The step is booked as soon as the strobe falls.
          state_d = S_GAP;
          cnt_d   = 8'd0;
          rem_d   = rem_q - STEP_ONE;
          case (phasesel_q)
            2'd1:    acc1_d = acc_bump(acc1_q, phasedir_q);
            2'd2:    acc2_d = acc_bump(acc2_q, phasedir_q);
            2'd3:    acc3_d = acc_bump(acc3_q, phasedir_q);
            default: acc1_d = acc1_q;
          endcase
        end else begin
          state_d = S_PULSE;
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          if (rem_q != '0) begin
            state_d = S_PULSE;
          end else if (LOCK_WAIT != 0) begin
            state_d = S_LOCKW;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          state_d = S_GAP;
        end
      end
      S_LOCKW: begin
        cnt_d      = 8'd0;
        lock_cnt_d = lock_cnt_q + 20'd1;
        if (lock_sync_q[1]) begin
          state_d = S_FIN;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_LOCKW;
        end
      end
      S_FIN, S_ERR: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs; completion strobes follow FIN/ERR by one cycle.
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      lock_cnt_q  <= 20'd0;
      rem_q       <= '0;
      phasesel_q  <= 2'd0;
      phasedir_q  <= 1'b0;
      acc1_q      <= 16'd0;
      acc2_q      <= 16'd0;
      acc3_q      <= 16'd0;
      lock_sync_q <= 2'b00;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      phasestep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      rem_q       <= rem_d;
      phasesel_q  <= phasesel_d;
      phasedir_q  <= phasedir_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      acc3_q      <= acc3_d;
      lock_sync_q <= {lock_sync_q[0], locked};
      cmd_ready_q <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_q == S_FIN) || (state_q == S_ERR);
      err_q       <= (state_q == S_ERR);
      phasestep_q <= (state_d == S_PULSE);
    end
  end

  assign cmd_ready    = cmd_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign acc1         = acc1_q;
  assign acc2         = acc2_q;
  assign acc3         = acc3_q;
  assign phasesel     = phasesel_q;
  assign phasedir     = phasedir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b0;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Bench for ecp5pll_phase_ctrl: two instances (no lock wait / lock wait with short
// timeout), a timeline model of expected outputs, and directed commands.
module tb_ecp5pll_phase_ctrl;

  localparam int S   = 4;
  localparam int P   = 4;
  localparam int T   = 12;
  localparam int TO  = 100;
  localparam int BIG = 1 << 30;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic [1:0]        vld = 2'b00;
  logic [1:0]        cmd_sel = 2'd0;
  logic signed [9:0] cmd_steps = 10'sd0;
  logic              locked = 1'b0;

  logic [1:0]  rdy, bsy, dn, er, pst, pdir, pload;
  logic [1:0]  psel [2];
  logic [15:0] acc [2][4];

  int n_checks = 0;
  int n_err    = 0;
  int rises0   = 0;

  always #5 clk = ~clk;

  ecp5pll_phase_ctrl #(.LOCK_WAIT(0)) dut0 (
    .clk_i(clk), .reset_n(reset_n), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
    .cmd_sel(cmd_sel), .cmd_steps(cmd_steps), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
    .acc1(acc[0][1]), .acc2(acc[0][2]), .acc3(acc[0][3]), .locked(locked),
    .phasesel(psel[0]), .phasedir(pdir[0]), .phasestep(pst[0]), .phaseloadreg(pload[0]));

  ecp5pll_phase_ctrl #(.LOCK_WAIT(1), .TIMEOUT_CYC(TO)) dut1 (
    .clk_i(clk), .reset_n(reset_n), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
    .cmd_sel(cmd_sel), .cmd_steps(cmd_steps), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
    .acc1(acc[1][1]), .acc2(acc[1][2]), .acc3(acc[1][3]), .locked(locked),
    .phasesel(psel[1]), .phasedir(pdir[1]), .phasestep(pst[1]), .phaseloadreg(pload[1]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each command is a timeline indexed by t = clock edges since its accept edge.
  bit          act_m [2];
  int          t_m [2], d_m [2], n_m [2], e_m [2];
  bit          norm_m [2], err_m [2], dir_m [2];
  logic [1:0]  cs_m [2], sel_m [2];
  logic [15:0] macc [2][4];
  logic [15:0] base_m [2];
  bit          lk1, lk2;

  function automatic int steps_done(int i, int t);
    int c;
    if (t < S + P) return 0;
    c = (t - S - P) / T + 1;
    return (c > n_m[i]) ? n_m[i] : c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      act_m[i] = 1'b0; t_m[i] = 0; d_m[i] = 0; sel_m[i] = 2'd0; dir_m[i] = 1'b0;
      for (int k = 0; k < 4; k++) macc[i][k] = 16'd0;
    end
    lk1 = 1'b0; lk2 = 1'b0;
  endtask

  task automatic model_accept(int i);
    int k;
    k = int'(cmd_steps);
    act_m[i] = 1'b1; t_m[i] = 0; cs_m[i] = cmd_sel;
    n_m[i] = (k < 0) ? -k : k;
    norm_m[i] = 1'b0; err_m[i] = 1'b0; d_m[i] = 1;
    if (cmd_sel == 2'd0) begin
      err_m[i] = 1'b1;
    end else if (n_m[i] != 0) begin
      norm_m[i] = 1'b1;
      e_m[i] = S + n_m[i] * T;
      d_m[i] = (i == 1) ? BIG : e_m[i] + 1;
      sel_m[i] = cmd_sel; dir_m[i] = (k < 0);
      base_m[i] = macc[i][cmd_sel];
    end
  endtask

  task automatic model_step();
    int c;
    for (int i = 0; i < 2; i++) begin
      if (!act_m[i] || t_m[i] >= d_m[i]) begin
        if (vld[i]) model_accept(i);
        else act_m[i] = 1'b0;
      end else begin
        t_m[i]++;
        // Lock wait: the synchronised lock seen during cycle t-1 is the pin value two edges ago.
        if (norm_m[i] && i == 1 && d_m[i] == BIG && t_m[i] - 1 >= e_m[i]) begin
          if (lk2) d_m[i] = t_m[i] + 1;
          else if (t_m[i] - 1 - e_m[i] == TO - 1) begin d_m[i] = t_m[i] + 1; err_m[i] = 1'b1; end
        end
        if (norm_m[i]) begin
          c = steps_done(i, t_m[i]);
          macc[i][cs_m[i]] = dir_m[i] ? base_m[i] - 16'(c) : base_m[i] + 16'(c);
        end
      end
    end
    lk2 = lk1; lk1 = locked;
  endtask

  function automatic logic [63:0] exp_vec(int i);
    bit r, b, d, e, s;
    int t;
    t = t_m[i];
    if (!act_m[i]) begin
      r = 1'b1; b = 1'b0; d = 1'b0; e = 1'b0; s = 1'b0;
    end else begin
      r = (t >= d_m[i]); b = (t < d_m[i]); d = (t == d_m[i]); e = d && err_m[i];
      s = norm_m[i] && t >= S && t < e_m[i] && ((t - S) % T) < P;
    end
    return {7'd0, r, b, d, e, s, sel_m[i], dir_m[i], 1'b0, macc[i][1], macc[i][2], macc[i][3]};
  endfunction

  function automatic logic [63:0] act_vec(int i);
    return {7'd0, rdy[i], bsy[i], dn[i], er[i], pst[i], psel[i], pdir[i], pload[i],
            acc[i][1], acc[i][2], acc[i][3]};
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) check($sformatf("cycle_dut%0d", i), act_vec(i), exp_vec(i));
  end

  initial forever begin
    @(posedge pst[0]);
    rises0++;
  end

  task automatic send(int i, logic [1:0] s, logic signed [9:0] k);
    @(negedge clk);
    cmd_sel = s; cmd_steps = k; vld[i] = 1'b1;
    @(negedge clk);
    vld[i] = 1'b0; cmd_sel = 2'd0; cmd_steps = 10'sd77;
  endtask

  task automatic wait_done(int i, int limit, output int lat, output logic e);
    lat = 0;
    while (!dn[i] && lat < limit) begin
      @(negedge clk);
      lat++;
    end
    e = er[i];
    if (!dn[i]) check($sformatf("done_timeout_dut%0d", i), 64'd0, 64'd1);
  endtask

  int   lat, r0;
  logic e;

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(rdy), 64'd3);
    check("reset_acc2", 64'(acc[0][2]), 64'd0);
    reset_n = 1'b1;

    // sel=2, +3 steps on the no-lock-wait instance
    r0 = rises0;
    send(0, 2'd2, 10'sd3);
    wait_done(0, 100, lat, e);
    check("lat_p3", 64'(lat), 64'd41);
    check("err_p3", 64'(e), 64'd0);
    check("pulses_p3", 64'(rises0 - r0), 64'd3);
    check("acc2_p3", 64'(acc[0][2]), 64'd3);

    // sel=1, -5 then +2 with cmd_valid held through done
    @(negedge clk);
    cmd_sel = 2'd1; cmd_steps = -10'sd5; vld[0] = 1'b1;
    @(negedge clk);
    cmd_steps = 10'sd2;
    wait_done(0, 200, lat, e);
    check("lat_m5", 64'(lat), 64'd65);
    check("acc1_m5", 64'(acc[0][1]), 64'h0000_0000_0000_FFFB);
    @(negedge clk);
    vld[0] = 1'b0;
    wait_done(0, 100, lat, e);
    check("lat_p2_b2b", 64'(lat), 64'd29);
    check("acc1_m3", 64'(acc[0][1]), 64'h0000_0000_0000_FFFD);

    // illegal sel
    r0 = rises0;
    send(0, 2'd0, 10'sd7);
    wait_done(0, 20, lat, e);
    check("lat_sel0", 64'(lat), 64'd1);
    check("err_sel0", 64'(e), 64'd1);
    check("pulses_sel0", 64'(rises0 - r0), 64'd0);

    // zero steps
    send(0, 2'd3, 10'sd0);
    wait_done(0, 20, lat, e);
    check("lat_zero", 64'(lat), 64'd1);
    check("err_zero", 64'(e), 64'd0);

    // most negative step count
    r0 = rises0;
    send(0, 2'd3, -10'sd512);
    wait_done(0, 7000, lat, e);
    check("lat_m512", 64'(lat), 64'd6149);
    check("pulses_m512", 64'(rises0 - r0), 64'd512);
    check("acc3_m512", 64'(acc[0][3]), 64'h0000_0000_0000_FE00);

    // lock wait, lock never arrives: 16 cycles of stepping + 100 wait + 1
    locked = 1'b0;
    send(1, 2'd1, 10'sd1);
    wait_done(1, 300, lat, e);
    check("lat_timeout", 64'(lat), 64'd117);
    check("err_timeout", 64'(e), 64'd1);

    // lock arrives 20 cycles into the wait
    send(1, 2'd1, 10'sd1);
    repeat (36) @(negedge clk);
    locked = 1'b1;
    wait_done(1, 300, lat, e);
    check("lat_locked", 64'(36 + lat), 64'd40);
    check("err_locked", 64'(e), 64'd0);
    check("acc1_lockdut", 64'(acc[1][1]), 64'd2);
    locked = 1'b0;

    // reset during the second pulse of a 4-step command
    send(0, 2'd2, 10'sd4);
    repeat (17) @(negedge clk);
    check("pulse2_high", 64'(pst[0]), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_step", 64'(pst[0]), 64'd0);
    check("rst_acc", {16'd0, acc[0][1], acc[0][2], acc[0][3]}, 64'd0);
    check("rst_done", 64'(dn[0]), 64'd0);
    check("rst_ready", 64'(rdy[0]), 64'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    send(0, 2'd3, 10'sd1);
    wait_done(0, 100, lat, e);
    check("lat_after_rst", 64'(lat), 64'd17);
    check("acc3_after_rst", 64'(acc[0][3]), 64'd1);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
